// File: rtl/perf_monitor_if.sv
// Bus bundle for perf_monitor: CPU trace/config inputs, VGA pixel inputs,
// per-channel status and overlay pixel outputs.
interface perf_monitor_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int PC_WIDTH     = 12
);
  logic [PC_WIDTH-1:0]              pc;
  logic [NUM_CHANNELS*PC_WIDTH-1:0] cfg_start_pc;
  logic [NUM_CHANNELS*PC_WIDTH-1:0] cfg_stop_pc;
  logic                             clear;
  logic [9:0]                       pixel_x;
  logic [9:0]                       pixel_y;
  logic [NUM_CHANNELS-1:0]          running;
  logic [NUM_CHANNELS-1:0]          done;
  logic [NUM_CHANNELS-1:0]          overflow;
  logic                             seconds_drawing_request;
  logic [7:0]                       seconds_rgb;

  modport master (
    output pc, cfg_start_pc, cfg_stop_pc, clear, pixel_x, pixel_y,
    input  running, done, overflow, seconds_drawing_request, seconds_rgb
  );
  modport slave (
    input  pc, cfg_start_pc, cfg_stop_pc, clear, pixel_x, pixel_y,
    output running, done, overflow, seconds_drawing_request, seconds_rgb
  );
endinterface

// File: rtl/perf_monitor.sv
// Multi-channel PC-triggered BCD interval timer with a 7-segment VGA overlay.
// Define PERF_MONITOR_RESTART_EN to let a start match re-arm a DONE channel.
module perf_monitor #(
  parameter int NUM_CHANNELS     = 4,
  parameter int PC_WIDTH         = 12,
  parameter int NUMBER_OF_DIGITS = 8,
  parameter int TICKS_PER_UNIT   = 50000,
  parameter int HEX_DIGIT_WIDTH  = 16,
  parameter int HEX_DIGIT_HEIGHT = 32,
  parameter int START_X          = 512,
  parameter int START_Y          = 0
) (
  input logic           CLK_50,
  input logic           reset,
  perf_monitor_if.slave bus
);
  localparam int DW = NUMBER_OF_DIGITS * 4;
  localparam int PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_UNIT - 1);
  localparam logic [DW-1:0] ALL9    = {NUMBER_OF_DIGITS{4'h9}};
  localparam int T = HEX_DIGIT_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, RUNNING, DONE} state_e;

  state_e                  state_q [NUM_CHANNELS];
  state_e                  state_d [NUM_CHANNELS];
  logic [PW-1:0]           pre_q   [NUM_CHANNELS];
  logic [PW-1:0]           pre_d   [NUM_CHANNELS];
  logic [DW-1:0]           cnt_q   [NUM_CHANNELS];
  logic [DW-1:0]           cnt_d   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ovf_q, ovf_d;
  logic [NUM_CHANNELS-1:0] start_hit, stop_hit;
  logic                    draw_q, draw_d;
  logic [7:0]              rgb_q, rgb_d;

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < NUMBER_OF_DIGITS; k++) begin
      if (carry) begin
        if (r[k*4 +: 4] == 4'd9) r[k*4 +: 4] = 4'd0;
        else begin
          r[k*4 +: 4] = r[k*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Segment bits ordered {a,b,c,d,e,f,g}; a/d span the full cell width.
  function automatic logic pix_lit(input logic [9:0] px, input logic [9:0] py,
                                   input int cx, input int cy, input logic [3:0] dig);
    int         lx, ly;
    logic [6:0] s;
    lx = int'(px) - cx;
    ly = int'(py) - cy;
    if (lx < 0 || lx >= HEX_DIGIT_WIDTH || ly < 0 || ly >= HEX_DIGIT_HEIGHT) return 1'b0;
    case (dig)
      4'd0: s = 7'b1111110;  4'd1: s = 7'b0110000;
      4'd2: s = 7'b1101101;  4'd3: s = 7'b1111001;
      4'd4: s = 7'b0110011;  4'd5: s = 7'b1011011;
      4'd6: s = 7'b1011111;  4'd7: s = 7'b1110000;
      4'd8: s = 7'b1111111;  4'd9: s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return (s[6] && ly < T) ||
           (s[5] && lx >= HEX_DIGIT_WIDTH - T && ly < HEX_DIGIT_HEIGHT / 2) ||
           (s[4] && lx >= HEX_DIGIT_WIDTH - T && ly >= HEX_DIGIT_HEIGHT / 2) ||
           (s[3] && ly >= HEX_DIGIT_HEIGHT - T) ||
           (s[2] && lx < T && ly >= HEX_DIGIT_HEIGHT / 2) ||
           (s[1] && lx < T && ly < HEX_DIGIT_HEIGHT / 2) ||
           (s[0] && ly >= HEX_DIGIT_HEIGHT / 2 - T / 2 && ly < HEX_DIGIT_HEIGHT / 2 - T / 2 + T);
  endfunction

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    assign start_hit[g]   = (bus.pc == bus.cfg_start_pc[g*PC_WIDTH +: PC_WIDTH]);
    assign stop_hit[g]    = (bus.pc == bus.cfg_stop_pc[g*PC_WIDTH +: PC_WIDTH]);
    assign bus.running[g] = (state_q[g] == RUNNING);
    assign bus.done[g]    = (state_q[g] == DONE);
  end
  assign bus.overflow                = ovf_q;
  assign bus.seconds_drawing_request = draw_q;
  assign bus.seconds_rgb             = rgb_q;

  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      state_d[i] = state_q[i];
      pre_d[i]   = pre_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: if (start_hit[i]) begin
          state_d[i] = RUNNING;
          pre_d[i]   = '0;
          cnt_d[i]   = '0;
        end
        RUNNING: begin
          // The stop cycle still counts, so the interval spans start..stop edges.
          if (pre_q[i] == PRE_MAX) begin
            pre_d[i] = '0;
            if (cnt_q[i] == ALL9) ovf_d[i] = 1'b1;
            else                  cnt_d[i] = bcd_inc(cnt_q[i]);
          end else begin
            pre_d[i] = pre_q[i] + 1'b1;
          end
          if (stop_hit[i]) state_d[i] = DONE;
        end
        DONE: begin
`ifdef PERF_MONITOR_RESTART_EN
          if (start_hit[i]) begin
            state_d[i] = RUNNING;
            pre_d[i]   = '0;
            cnt_d[i]   = '0;
          end
`endif
        end
        default: state_d[i] = IDLE;
      endcase
      if (bus.clear) begin
        state_d[i] = IDLE;
        pre_d[i]   = '0;
        cnt_d[i]   = '0;
      end
    end
    if (bus.clear) ovf_d = '0;
  end

  always_comb begin
    draw_d = 1'b0;
    rgb_d  = 8'h00;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      for (int d = 0; d < NUMBER_OF_DIGITS; d++) begin
        if (pix_lit(bus.pixel_x, bus.pixel_y,
                    START_X + d * HEX_DIGIT_WIDTH, START_Y + i * HEX_DIGIT_HEIGHT,
                    cnt_q[i][(NUMBER_OF_DIGITS-1-d)*4 +: 4])) begin
          draw_d = 1'b1;
          rgb_d  = ovf_q[i] ? 8'hE0 : (state_q[i] == DONE) ? 8'h1C : 8'hFF;
        end
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= IDLE;
        pre_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
      ovf_q  <= '0;
      draw_q <= 1'b0;
      rgb_q  <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        pre_q[i]   <= pre_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ovf_q  <= ovf_d;
      draw_q <= draw_d;
      rgb_q  <= rgb_d;
    end
  end
endmodule
